// File: rtl/mem_arb.sv
// Two-port memory arbiter: a fetch port and a load/store port share one memory
// port, with one outstanding transaction and anti-starvation for fetch.
module mem_arb #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [DW/8-1:0] ls_be,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);
  localparam int BW = DW / 8;
  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  typedef struct packed {
    logic          we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_cmd_t;

  state_t   state, state_nxt;
  mem_cmd_t cmd_q, cmd_nxt;
  logic     own_ls;
  logic [3:0] starve_cnt;
  logic     arb, sel_if;

  // Gating on rst keeps both grants low during the reset cycle itself.
  assign arb    = (state == IDLE) && en && !rst && (if_req || ls_req);
  assign sel_if = if_req && (!ls_req || (starve_cnt == LIM));

  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    cmd_nxt   = cmd_q;
    case (state)
      IDLE: if (arb) begin
        state_nxt = REQ;
        if (sel_if) begin
          if_gnt  = 1'b1;
          cmd_nxt = '{we: 1'b0, be: '1, addr: if_addr, wdata: '0};
        end else begin
          ls_gnt  = 1'b1;
          cmd_nxt = '{we: ls_we, be: ls_be, addr: ls_addr, wdata: ls_wdata};
        end
      end
      REQ:  if (mem_gnt) state_nxt = WAIT;
      WAIT: if (mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_q      <= '0;
      own_ls     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      cmd_q <= cmd_nxt;
      if (arb) begin
        own_ls <= !sel_if;
        if (sel_if)
          starve_cnt <= '0;
        else if (if_req && (starve_cnt != LIM))
          starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  assign mem_req   = (state == REQ);
  assign mem_we    = cmd_q.we;
  assign mem_be    = cmd_q.be;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;

  // Responses outside WAIT are stale or spurious and never reach a port.
  assign if_rvalid = (state == WAIT) && mem_rvalid && !own_ls;
  assign ls_rvalid = (state == WAIT) && mem_rvalid &&  own_ls;
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: fetch, contention, stalls, en gating, reset.
module tb_mem_arb;
  localparam int AW = 32, DW = 32;
  logic clk = 1'b0;
  logic rst, en;
  logic if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [3:0] ls_be;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  int checks = 0, failures = 0;
  int order [5] = '{0, 0, 0, 0, 1};

  always #5 clk = ~clk;

  mem_arb #(.AW(AW), .DW(DW), .STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst), .en(en),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
  task automatic cyc();
    @(posedge clk); #1;
  endtask
  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1; en = 1; if_req = 1; if_addr = 32'h100;
    ls_req = 0; ls_we = 0; ls_be = 0; ls_addr = 0; ls_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    cyc(); settle();
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
    cyc(); rst = 0;

    // Single fetch, zero-wait memory
    mem_gnt = 1; settle();
    chk("f_if_gnt", 32'(if_gnt), 32'd1);
    chk("f_ls_gnt", 32'(ls_gnt), 32'd0);
    cyc(); if_req = 0; if_addr = 32'h999; settle();
    chk("f_mem_req", 32'(mem_req), 32'd1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_we_be", 32'({mem_we, mem_be}), 32'h0F);
    chk("f_mem_wdata", mem_wdata, 32'h0);
    cyc(); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; settle();
    chk("f_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("f_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("f_ls_rvalid", 32'(ls_rvalid), 32'd0);
    chk("f_wait_mem_req", 32'(mem_req), 32'd0);
    cyc(); mem_rvalid = 0; settle();
    chk("f_idle_rvalid", 32'(if_rvalid), 32'd0);

    // Contention: starve_cnt is 0 after the fetch win
    if_req = 1; ls_req = 1; mem_rvalid = 1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("c_if_gnt%0d", i), 32'(if_gnt), 32'(order[i]));
      chk($sformatf("c_ls_gnt%0d", i), 32'(ls_gnt), 32'(1 - order[i]));
      cyc(); cyc(); settle();
      chk($sformatf("c_rv%0d", i), 32'({if_rvalid, ls_rvalid}), order[i] ? 32'd2 : 32'd1);
      cyc();
    end
    if_req = 0; ls_req = 0; mem_rvalid = 0;

    // Stalled ls write
    ls_req = 1; ls_we = 1; ls_be = 4'h3; ls_addr = 32'h20; ls_wdata = 32'h1234; mem_gnt = 0;
    settle();
    chk("s_ls_gnt", 32'(ls_gnt), 32'd1);
    cyc(); ls_req = 0; ls_addr = 32'hFFFF; ls_be = 4'hC; ls_wdata = 32'h5555;
    for (int i = 0; i < 5; i++) begin
      mem_rvalid = (i == 2);
      settle();
      chk($sformatf("s_req%0d", i), 32'(mem_req), 32'd1);
      chk($sformatf("s_addr%0d", i), mem_addr, 32'h20);
      chk($sformatf("s_we_be%0d", i), 32'({mem_we, mem_be}), 32'h13);
      chk($sformatf("s_wdata%0d", i), mem_wdata, 32'h1234);
      chk($sformatf("s_rv%0d", i), 32'(ls_rvalid), 32'd0);
      cyc();
    end
    mem_rvalid = 0; mem_gnt = 1; settle();
    chk("s_req_gnt", 32'(mem_req), 32'd1);
    cyc(); mem_gnt = 0; settle();
    chk("s_wait_rv", 32'(ls_rvalid), 32'd0);
    cyc(); mem_rvalid = 1; mem_rdata = 32'hA5; settle();
    chk("s_ls_rvalid", 32'(ls_rvalid), 32'd1);
    chk("s_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("s_ls_rdata", ls_rdata, 32'hA5);
    cyc(); mem_rvalid = 0; ls_we = 0;

    // en gating
    en = 0; if_req = 1; if_addr = 32'h40; settle();
    chk("e_no_gnt", 32'({if_gnt, ls_gnt}), 32'd0);
    cyc(); settle();
    chk("e_no_mem_req", 32'(mem_req), 32'd0);
    en = 1; mem_gnt = 1; #0 settle();
    chk("e_if_gnt", 32'(if_gnt), 32'd1);
    cyc(); en = 0; settle();
    chk("e_req_kept", 32'(mem_req), 32'd1);
    chk("e_addr", mem_addr, 32'h40);
    cyc(); mem_rvalid = 1; mem_rdata = 32'hCAFE; settle();
    chk("e_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("e_if_rdata", if_rdata, 32'hCAFE);
    chk("e_wait_gnt", 32'(if_gnt), 32'd0);
    cyc(); mem_rvalid = 0; settle();
    chk("e_idle_gnt", 32'(if_gnt), 32'd0);
    chk("e_idle_req", 32'(mem_req), 32'd0);
    cyc();

    // Reset in WAIT, then stale response; ls win with if pending bumps starve_cnt
    en = 1; if_req = 1; ls_req = 1; settle();
    chk("r_ls_gnt", 32'(ls_gnt), 32'd1);
    cyc(); if_req = 0; ls_req = 0;
    cyc(); rst = 1; settle();
    chk("r_wait_rv", 32'(ls_rvalid), 32'd0);
    cyc(); rst = 0; mem_rvalid = 1; settle();
    chk("r_stale_rv", 32'({if_rvalid, ls_rvalid}), 32'd0);
    chk("r_mem_req", 32'(mem_req), 32'd0);
    cyc(); settle();

    // Spurious rvalid in IDLE
    chk("sp_rv", 32'({if_rvalid, ls_rvalid}), 32'd0);
    chk("sp_mem_req", 32'(mem_req), 32'd0);
    cyc();

    // starve_cnt was cleared by reset: four ls wins before fetch
    if_req = 1; ls_req = 1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("r_if_gnt%0d", i), 32'(if_gnt), 32'(order[i]));
      chk($sformatf("r_ls_gnt%0d", i), 32'(ls_gnt), 32'(1 - order[i]));
      cyc(); cyc(); cyc();
    end
    if_req = 0; ls_req = 0; mem_rvalid = 0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
